// File: rtl/gmii_tx_sequencer.sv
// GMII transmit sequencer: round-robin arbitration of two frame sources, then preamble/SFD/payload/IPG.
// Optional macro TX_SEQ_ERR_INJ_EN adds the err_inject input for marking payload bytes with TX_ER.
module gmii_tx_sequencer #(
    parameter int         LEN_W     = 8,
    parameter int         MAX_LEN   = 64,
    parameter int         IPG       = 12,
    parameter logic [2:0] XMIT_DATA = 3'b100
) (
    input  logic             GTX_CLK,
    input  logic             mr_main_reset,
    input  logic [2:0]       xmit,
    input  logic             receiving,
    input  logic             repeater_mode,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [LEN_W-1:0] len_a,
    input  logic [LEN_W-1:0] len_b,
    input  logic [7:0]       seed_a,
    input  logic [7:0]       seed_b,
`ifdef TX_SEQ_ERR_INJ_EN
    input  logic             err_inject,
`endif
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             busy,
    output logic [7:0]       TXD,
    output logic             TX_EN,
    output logic             TX_ER,
    output logic [15:0]      frames_sent,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_SFD   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    // One shared counter serves preamble, payload and gap; size it for the widest use.
    localparam int IPG_W  = (IPG > 2) ? $clog2(IPG) : 1;
    localparam int CNT_W0 = (LEN_W > IPG_W) ? LEN_W : IPG_W;
    localparam int CNT_W  = (CNT_W0 > 3) ? CNT_W0 : 3;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(6);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(IPG - 2);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic [7:0]       r_seed;
    logic             r_last_b;
    logic [7:0]       r_txd;
    logic             r_tx_en;
    logic             r_tx_er;
    logic             r_gnt_a;
    logic             r_gnt_b;
    logic             r_busy;
    logic [15:0]      r_frames_sent;

    logic             w_crs;
    logic             w_qual_a;
    logic             w_qual_b;
    logic             w_launch;
    logic             w_pick_a;
    logic             w_abort;
    logic             w_err_inj;
    logic [LEN_W-1:0] w_len_a_clamp;
    logic [LEN_W-1:0] w_len_b_clamp;
    logic [CNT_W-1:0] w_len_last;

    logic [2:0]       w_nxt_state;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [LEN_W-1:0] w_nxt_len;
    logic [7:0]       w_nxt_seed;
    logic             w_nxt_last_b;
    logic [7:0]       w_nxt_txd;
    logic             w_nxt_en;
    logic             w_nxt_er;
    logic             w_nxt_gnt_a;
    logic             w_nxt_gnt_b;
    logic             w_frame_done;

    assign w_crs    = receiving & ~repeater_mode;
    assign w_qual_a = req_a && (len_a != '0);
    assign w_qual_b = req_b && (len_b != '0);
    assign w_launch = (xmit == XMIT_DATA) && !w_crs && (w_qual_a || w_qual_b);
    // r_last_b set means B was granted last, so A wins a tie.
    assign w_pick_a = w_qual_a && (!w_qual_b || r_last_b);
    assign w_abort  = (xmit != XMIT_DATA);

    assign w_len_a_clamp = (len_a > LEN_MAX) ? LEN_MAX : len_a;
    assign w_len_b_clamp = (len_b > LEN_MAX) ? LEN_MAX : len_b;
    assign w_len_last    = CNT_W'(r_len) - CNT_W'(1);

`ifdef TX_SEQ_ERR_INJ_EN
    assign w_err_inj = err_inject;
`else
    assign w_err_inj = 1'b0;
`endif

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        w_nxt_len    = r_len;
        w_nxt_seed   = r_seed;
        w_nxt_last_b = r_last_b;
        w_nxt_txd    = 8'h00;
        w_nxt_en     = 1'b0;
        w_nxt_er     = 1'b0;
        w_nxt_gnt_a  = 1'b0;
        w_nxt_gnt_b  = 1'b0;
        w_frame_done = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_nxt_state = S_PRE;
                    w_nxt_cnt   = '0;
                    w_nxt_txd   = 8'h55;
                    w_nxt_en    = 1'b1;
                    if (w_pick_a) begin
                        w_nxt_gnt_a  = 1'b1;
                        w_nxt_len    = w_len_a_clamp;
                        w_nxt_seed   = seed_a;
                        w_nxt_last_b = 1'b0;
                    end else begin
                        w_nxt_gnt_b  = 1'b1;
                        w_nxt_len    = w_len_b_clamp;
                        w_nxt_seed   = seed_b;
                        w_nxt_last_b = 1'b1;
                    end
                end
            end

            S_PRE: begin
                if (w_abort) begin
                    w_nxt_state = S_ABORT;
                    w_nxt_en    = 1'b1;
                    w_nxt_er    = 1'b1;
                end else if (r_cnt == PRE_LAST) begin
                    w_nxt_state = S_SFD;
                    w_nxt_txd   = 8'hD5;
                    w_nxt_en    = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                    w_nxt_txd = 8'h55;
                    w_nxt_en  = 1'b1;
                end
            end

            S_SFD: begin
                if (w_abort) begin
                    w_nxt_state = S_ABORT;
                    w_nxt_en    = 1'b1;
                    w_nxt_er    = 1'b1;
                end else begin
                    w_nxt_state = S_DATA;
                    w_nxt_cnt   = '0;
                    w_nxt_txd   = r_seed;
                    w_nxt_en    = 1'b1;
                    w_nxt_er    = w_err_inj;
                end
            end

            S_DATA: begin
                if (w_abort) begin
                    w_nxt_state = S_ABORT;
                    w_nxt_en    = 1'b1;
                    w_nxt_er    = 1'b1;
                end else if (r_cnt == w_len_last) begin
                    w_nxt_state  = S_GAP;
                    w_nxt_cnt    = '0;
                    w_frame_done = 1'b1;
                end else begin
                    // TXD holds the current payload byte, so the next one is simply +1.
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                    w_nxt_txd = r_txd + 8'd1;
                    w_nxt_en  = 1'b1;
                    w_nxt_er  = w_err_inj;
                end
            end

            S_ABORT: begin
                w_nxt_state = S_GAP;
                w_nxt_cnt   = '0;
            end

            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_len         <= '0;
            r_seed        <= 8'h00;
            r_last_b      <= 1'b1;
            r_txd         <= 8'h00;
            r_tx_en       <= 1'b0;
            r_tx_er       <= 1'b0;
            r_gnt_a       <= 1'b0;
            r_gnt_b       <= 1'b0;
            r_busy        <= 1'b0;
            r_frames_sent <= 16'h0000;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_len    <= w_nxt_len;
            r_seed   <= w_nxt_seed;
            r_last_b <= w_nxt_last_b;
            r_txd    <= w_nxt_txd;
            r_tx_en  <= w_nxt_en;
            r_tx_er  <= w_nxt_er;
            r_gnt_a  <= w_nxt_gnt_a;
            r_gnt_b  <= w_nxt_gnt_b;
            r_busy   <= (w_nxt_state != S_IDLE);
            if (w_frame_done) begin
                r_frames_sent <= r_frames_sent + 16'd1;
            end
        end
    end

    assign gnt_a       = r_gnt_a;
    assign gnt_b       = r_gnt_b;
    assign busy        = r_busy;
    assign TXD         = r_txd;
    assign TX_EN       = r_tx_en;
    assign TX_ER       = r_tx_er;
    assign frames_sent = r_frames_sent;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_gmii_tx_sequencer.sv
// Bench for gmii_tx_sequencer: directed scenarios plus randomized traffic against a frame-timeline model.
module tb_gmii_tx_sequencer;

    localparam int         LEN_W   = 8;
    localparam int         MAX_LEN = 64;
    localparam int         IPG     = 12;
    localparam logic [2:0] XD      = 3'b100;

    logic             GTX_CLK = 1'b0;
    logic             mr_main_reset;
    logic [2:0]       xmit;
    logic             receiving;
    logic             repeater_mode;
    logic             req_a;
    logic             req_b;
    logic [LEN_W-1:0] len_a;
    logic [LEN_W-1:0] len_b;
    logic [7:0]       seed_a;
    logic [7:0]       seed_b;
    logic             err_inject;
    logic             gnt_a;
    logic             gnt_b;
    logic             busy;
    logic [7:0]       TXD;
    logic             TX_EN;
    logic             TX_ER;
    logic [15:0]      frames_sent;
    logic [2:0]       dbg_state;

    always #5 GTX_CLK = ~GTX_CLK;

    gmii_tx_sequencer #(
        .LEN_W(LEN_W), .MAX_LEN(MAX_LEN), .IPG(IPG), .XMIT_DATA(XD)
    ) dut (
        .GTX_CLK(GTX_CLK),
        .mr_main_reset(mr_main_reset),
        .xmit(xmit),
        .receiving(receiving),
        .repeater_mode(repeater_mode),
        .req_a(req_a),
        .req_b(req_b),
        .len_a(len_a),
        .len_b(len_b),
        .seed_a(seed_a),
        .seed_b(seed_b),
`ifdef TX_SEQ_ERR_INJ_EN
        .err_inject(err_inject),
`endif
        .gnt_a(gnt_a),
        .gnt_b(gnt_b),
        .busy(busy),
        .TXD(TXD),
        .TX_EN(TX_EN),
        .TX_ER(TX_ER),
        .frames_sent(frames_sent),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a frame is a timeline t = cycles since its first preamble byte.
    int          m_t = -1;
    int          m_txlen = 0;
    int          m_len = 0;
    logic [7:0]  m_seed = 8'h00;
    logic        m_last_b = 1'b1;
    logic        m_aborted = 1'b0;
    logic        m_gnt_a = 1'b0;
    logic        m_gnt_b = 1'b0;
    logic        m_er_now = 1'b0;
    logic [15:0] m_frames = 16'h0000;
    int          wrap_tok = 0;
    int          wrap_ack = 0;
    logic        chk_en = 1'b0;

    always @(posedge GTX_CLK) begin
        logic qa, qb, pa;
        int   la, lb;
        m_gnt_a  = 1'b0;
        m_gnt_b  = 1'b0;
        m_er_now = 1'b0;
        if (mr_main_reset) begin
            m_t       = -1;
            m_frames  = 16'h0000;
            m_last_b  = 1'b1;
            m_aborted = 1'b0;
        end else begin
            if (wrap_ack != wrap_tok) begin
                m_frames = 16'hFFFF;
                wrap_ack = wrap_tok;
            end
            if (m_t < 0) begin
                qa = req_a && (len_a != 0);
                qb = req_b && (len_b != 0);
                if (xmit == XD && !(receiving && !repeater_mode) && (qa || qb)) begin
                    pa = qa && (!qb || m_last_b);
                    la = (int'(len_a) > MAX_LEN) ? MAX_LEN : int'(len_a);
                    lb = (int'(len_b) > MAX_LEN) ? MAX_LEN : int'(len_b);
                    m_len     = pa ? la : lb;
                    m_seed    = pa ? seed_a : seed_b;
                    m_gnt_a   = pa;
                    m_gnt_b   = !pa;
                    m_last_b  = !pa;
                    m_t       = 0;
                    m_txlen   = 8 + m_len;
                    m_aborted = 1'b0;
                end
            end else begin
                if (!m_aborted && m_t < 8 + m_len && xmit != XD) begin
                    m_aborted = 1'b1;
                    m_txlen   = m_t + 2;
                end else if (!m_aborted && m_t == 8 + m_len - 1) begin
                    m_frames = m_frames + 16'd1;
                end
                m_t++;
                if (m_t == m_txlen + IPG - 1) m_t = -1;
`ifdef TX_SEQ_ERR_INJ_EN
                if (err_inject && !m_aborted && m_t >= 8 && m_t < 8 + m_len) m_er_now = 1'b1;
`endif
            end
        end
    end

    always @(negedge GTX_CLK) begin
        logic [7:0] e_txd;
        logic       e_en, e_er;
        if (chk_en) begin
            e_txd = 8'h00;
            e_en  = 1'b0;
            e_er  = 1'b0;
            if (m_t >= 0 && m_t < m_txlen) begin
                e_en = 1'b1;
                if (m_aborted && m_t == m_txlen - 1) e_er = 1'b1;
                else begin
                    e_er  = m_er_now;
                    e_txd = (m_t < 7) ? 8'h55 : (m_t == 7) ? 8'hD5 : m_seed + 8'(m_t - 8);
                end
            end
            check("txd", 32'(TXD), 32'(e_txd));
            check("tx_en", 32'(TX_EN), 32'(e_en));
            check("tx_er", 32'(TX_ER), 32'(e_er));
            check("gnt_a", 32'(gnt_a), 32'(m_gnt_a));
            check("gnt_b", 32'(gnt_b), 32'(m_gnt_b));
            check("busy", 32'(busy), 32'(m_t >= 0));
            check("frames_sent", 32'(frames_sent), 32'(m_frames));
        end
    end

    // Observation logs used by the directed scenarios.
    logic [7:0] cap_q[$];
    int         gap_q[$];
    int         gnt_log[$];
    int         low_run = 0;
    logic       seen_frame = 1'b0;
    int         er_cnt = 0;

    always @(negedge GTX_CLK) begin
        if (mr_main_reset) begin
            low_run    = 0;
            seen_frame = 1'b0;
        end else if (TX_EN) begin
            if (seen_frame && low_run > 0) gap_q.push_back(low_run);
            low_run    = 0;
            seen_frame = 1'b1;
            cap_q.push_back(TXD);
        end else begin
            low_run++;
        end
        if (gnt_a) gnt_log.push_back(0);
        if (gnt_b) gnt_log.push_back(1);
        if (TX_ER) er_cnt++;
    end

    task automatic do_reset();
        @(negedge GTX_CLK);
        mr_main_reset = 1'b1;
        repeat (2) @(negedge GTX_CLK);
        mr_main_reset = 1'b0;
    endtask

    task automatic wait_gnt(input string tag, input int max_cyc, output int who);
        who = -1;
        for (int i = 0; i < max_cyc && who < 0; i++) begin
            @(negedge GTX_CLK);
            if (gnt_a) who = 0;
            else if (gnt_b) who = 1;
        end
        if (who < 0) check({tag, "_gnt_timeout"}, 32'(gnt_a | gnt_b), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc && busy; i++) @(negedge GTX_CLK);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int who, cs, gl, gs, ec;
        logic [7:0] sd;
        mr_main_reset = 1'b1;
        xmit = XD; receiving = 1'b0; repeater_mode = 1'b0;
        req_a = 1'b0; req_b = 1'b0; len_a = '0; len_b = '0;
        seed_a = 8'h00; seed_b = 8'h00; err_inject = 1'b0;
        repeat (2) @(negedge GTX_CLK);
        check("rst_txen", 32'(TX_EN), 32'd0);
        check("rst_txd", 32'(TXD), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frames", 32'(frames_sent), 32'd0);
        mr_main_reset = 1'b0;
        #1 chk_en = 1'b1;

        // Single request, len 4, seed F0.
        @(negedge GTX_CLK);
        cs = cap_q.size(); gl = gnt_log.size();
        len_a = 8'd4; seed_a = 8'hF0; req_a = 1'b1;
        wait_gnt("single", 20, who);
        req_a = 1'b0;
        check("single_who", 32'(who), 32'd0);
        wait_idle("single", 60);
        repeat (2) @(negedge GTX_CLK);
        check("single_len", 32'(cap_q.size() - cs), 32'd12);
        check("single_gnts", 32'(gnt_log.size() - gl), 32'd1);
        for (int i = 0; i < 12 && cs + i < cap_q.size(); i++)
            check("single_byte", 32'(cap_q[cs+i]),
                  (i < 7) ? 32'h55 : (i == 7) ? 32'hD5 : 32'hF0 + 32'(i - 8));
        check("single_frames", 32'(frames_sent), 32'd1);

        // Round-robin tie from reset: A, B, A with 12-cycle gaps.
        do_reset();
        gl = gnt_log.size(); gs = gap_q.size();
        len_a = 8'd2; len_b = 8'd2; req_a = 1'b1; req_b = 1'b1;
        for (int i = 0; i < 150 && gnt_log.size() < gl + 3; i++) @(negedge GTX_CLK);
        req_a = 1'b0; req_b = 1'b0;
        wait_idle("rr", 60);
        repeat (2) @(negedge GTX_CLK);
        check("rr_count", 32'(gnt_log.size() - gl), 32'd3);
        if (gnt_log.size() >= gl + 3) begin
            check("rr_first", 32'(gnt_log[gl]), 32'd0);
            check("rr_second", 32'(gnt_log[gl+1]), 32'd1);
            check("rr_third", 32'(gnt_log[gl+2]), 32'd0);
        end
        check("rr_gapcount", 32'(gap_q.size() - gs), 32'd2);
        for (int i = gs; i < gap_q.size(); i++) check("rr_gap", 32'(gap_q[i]), 32'(IPG));

        // Deferral on carrier sense, released by repeater_mode then by receiving.
        gl = gnt_log.size();
        receiving = 1'b1; repeater_mode = 1'b0;
        len_b = 8'd3; seed_b = 8'($urandom_range(0, 255)); req_b = 1'b1;
        repeat (20) @(negedge GTX_CLK);
        check("defer_nognt", 32'(gnt_log.size() - gl), 32'd0);
        repeater_mode = 1'b1;
        @(negedge GTX_CLK);
        check("defer_rep_gnt", 32'(gnt_b), 32'd1);
        req_b = 1'b0;
        wait_idle("defer1", 60);
        repeater_mode = 1'b0;
        req_b = 1'b1;
        repeat (10) @(negedge GTX_CLK);
        receiving = 1'b0;
        @(negedge GTX_CLK);
        check("defer_rx_gnt", 32'(gnt_b), 32'd1);
        req_b = 1'b0;
        wait_idle("defer2", 60);

        // Abort during payload byte 2 of a 10-byte frame.
        do_reset();
        sd = 8'($urandom_range(0, 255));
        len_a = 8'd10; seed_a = sd; req_a = 1'b1;
        wait_gnt("abort", 20, who);
        req_a = 1'b0;
        repeat (10) @(negedge GTX_CLK);
        check("abort_byte2", 32'(TXD), 32'(8'(sd + 8'd2)));
        xmit = 3'b001;
        @(negedge GTX_CLK);
        xmit = XD;
        check("abort_en", 32'(TX_EN), 32'd1);
        check("abort_er", 32'(TX_ER), 32'd1);
        check("abort_txd", 32'(TXD), 32'd0);
        @(negedge GTX_CLK);
        check("abort_gap_en", 32'(TX_EN), 32'd0);
        wait_idle("abort", 40);
        check("abort_frames", 32'(frames_sent), 32'd0);

        // Clamp to MAX_LEN and counter wrap.
        @(negedge GTX_CLK);
        #1 force dut.r_frames_sent = 16'hFFFF;
        wrap_tok++;
        @(negedge GTX_CLK);
        #1 release dut.r_frames_sent;
        @(negedge GTX_CLK);
        cs = cap_q.size();
        len_a = 8'd200; seed_a = 8'hFE; req_a = 1'b1;
        wait_gnt("clamp", 20, who);
        req_a = 1'b0;
        wait_idle("clamp", 120);
        repeat (2) @(negedge GTX_CLK);
        check("clamp_len", 32'(cap_q.size() - cs), 32'(8 + MAX_LEN));
        if (cap_q.size() - cs >= 8 + MAX_LEN) begin
            check("clamp_b0", 32'(cap_q[cs+8]), 32'hFE);
            check("clamp_b1", 32'(cap_q[cs+9]), 32'hFF);
            check("clamp_b2", 32'(cap_q[cs+10]), 32'h00);
            check("clamp_blast", 32'(cap_q[cs+7+MAX_LEN]), 32'h3D);
        end
        check("wrap_frames", 32'(frames_sent), 32'd0);

        // Reset in the middle of the preamble.
        len_a = 8'd5; req_a = 1'b1;
        wait_gnt("midrst", 20, who);
        req_a = 1'b0;
        repeat (2) @(negedge GTX_CLK);
        mr_main_reset = 1'b1;
        @(negedge GTX_CLK);
        mr_main_reset = 1'b0;
        check("midrst_en", 32'(TX_EN), 32'd0);
        check("midrst_txd", 32'(TXD), 32'd0);
        check("midrst_er", 32'(TX_ER), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);

`ifdef TX_SEQ_ERR_INJ_EN
        ec = er_cnt;
        len_a = 8'd6; req_a = 1'b1;
        wait_gnt("errinj", 20, who);
        req_a = 1'b0;
        repeat (9) @(negedge GTX_CLK);
        err_inject = 1'b1;
        @(negedge GTX_CLK);
        err_inject = 1'b0;
        wait_idle("errinj", 40);
        check("errinj_count", 32'(er_cnt - ec), 32'd1);
`else
        ec = 0;
`endif

        // Randomized traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge GTX_CLK);
            if ($urandom_range(0, 9) < 3) req_a = ~req_a;
            if ($urandom_range(0, 9) < 3) req_b = ~req_b;
            if ($urandom_range(0, 9) == 0)
                len_a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(60, 255)) : 8'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0)
                len_b = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(60, 255)) : 8'($urandom_range(0, 12));
            seed_a        = 8'($urandom_range(0, 255));
            seed_b        = 8'($urandom_range(0, 255));
            xmit          = ($urandom_range(0, 99) < 2) ? 3'($urandom_range(0, 3)) : XD;
            receiving     = ($urandom_range(0, 9) < 2);
            repeater_mode = ($urandom_range(0, 1) == 1);
            mr_main_reset = ($urandom_range(0, 999) == 0);
`ifdef TX_SEQ_ERR_INJ_EN
            err_inject    = ($urandom_range(0, 19) == 0);
`endif
        end
        @(negedge GTX_CLK);
        req_a = 1'b0; req_b = 1'b0; xmit = XD; mr_main_reset = 1'b0; err_inject = 1'b0;
        wait_idle("final", 200);
        repeat (2) @(negedge GTX_CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
